// File: rtl/detect_event_logger.sv
// Timestamps qualified detections from the serial pattern detector into a small FIFO.
// Optional macro DETLOG_RISE_EN: qualify only on the rising edge of det.
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det,
    input  logic                     clear,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         det_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            q;
    logic            push_req;
    logic            pop;
    logic            push;
    logic            full;

`ifdef DETLOG_RISE_EN
    logic det_d;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            det_d <= 1'b0;
        end else begin
            det_d <= det;
        end
    end

    always_comb q = det & ~det_d;
`else
    always_comb q = det;
`endif

    // clear masks both the push and the pop of the same cycle
    always_comb begin
        full      = (fifo_count == FULL_CNT);
        evt_valid = (fifo_count != '0);
        push_req  = q & ~clear;
        pop       = evt_valid & evt_ready & ~clear;
        push      = push_req & (~full | pop);
        evt_ts    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            det_count  <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            det_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ts;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && det_count != '1) begin
                det_count <= det_count + CNT_W'(1);
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detect_event_logger.sv
// Bench for detect_event_logger: a 16-bit/8-bit instance and a 4-bit/2-bit instance
// share one stimulus stream and are checked against one queue-based model.
module tb_detect_event_logger;

    logic        tb_clk;
    logic        rst;
    logic        det;
    logic        clear;
    logic        evt_ready;

    logic        b_valid;
    logic [15:0] b_ts;
    logic [2:0]  b_count;
    logic [7:0]  b_det_count;
    logic        b_ovf;

    logic        s_valid;
    logic [3:0]  s_ts;
    logic [2:0]  s_count;
    logic [1:0]  s_det_count;
    logic        s_ovf;

    int errors = 0;
    int checks = 0;

    detect_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) u_big (
        .clk(tb_clk), .rst(rst), .det(det), .clear(clear), .evt_ready(evt_ready),
        .evt_valid(b_valid), .evt_ts(b_ts), .fifo_count(b_count),
        .det_count(b_det_count), .overflow(b_ovf)
    );

    detect_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) u_small (
        .clk(tb_clk), .rst(rst), .det(det), .clear(clear), .evt_ready(evt_ready),
        .evt_valid(s_valid), .evt_ts(s_ts), .fifo_count(s_count),
        .det_count(s_det_count), .overflow(s_ovf)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Model: stamps kept as 16-bit values; narrow instance compares the low nibble.
    int mq[$];
    int mts = 0;
    int mn = 0;
    bit movf = 0;
    bit mprev = 0;
    bit mvalid = 0;

    always @(posedge tb_clk) begin
        bit qual;
        bit popping;
        if (rst) begin
            mq.delete();
            mts = 0; mn = 0; movf = 0; mprev = 0; mvalid = 1;
        end else if (mvalid) begin
`ifdef DETLOG_RISE_EN
            qual = det && !mprev;
`else
            qual = det;
`endif
            if (clear) begin
                mq.delete();
                mn = 0; movf = 0; mprev = 0;
            end else begin
                mprev = det;
                popping = (mq.size() > 0) && evt_ready;
                if (popping) void'(mq.pop_front());
                if (qual) begin
                    mn++;
                    if (mq.size() < 4) mq.push_back(mts);
                    else movf = 1;
                end
            end
            mts = (mts + 1) & 16'hFFFF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge tb_clk) begin
        if (mvalid) begin
            chk("b_valid", 32'(b_valid), 32'(mq.size() != 0));
            chk("b_count", 32'(b_count), 32'(mq.size()));
            chk("b_det_count", 32'(b_det_count), 32'(mn > 255 ? 255 : mn));
            chk("b_ovf", 32'(b_ovf), 32'(movf));
            chk("s_valid", 32'(s_valid), 32'(mq.size() != 0));
            chk("s_count", 32'(s_count), 32'(mq.size()));
            chk("s_det_count", 32'(s_det_count), 32'(mn > 3 ? 3 : mn));
            chk("s_ovf", 32'(s_ovf), 32'(movf));
            if (mq.size() != 0) begin
                chk("b_ts", 32'(b_ts), 32'(mq[0] & 16'hFFFF));
                chk("s_ts", 32'(s_ts), 32'(mq[0] & 4'hF));
            end
        end
    end

    task automatic step(input logic d, input logic c, input logic r);
        @(negedge tb_clk);
        rst = 1'b0; det = d; clear = c; evt_ready = r;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge tb_clk);
        rst = 1'b1; det = 1'b1; clear = 1'b0; evt_ready = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
    endtask

    task automatic idle_to(input int val, input int mask);
        int guard = 0;
        while ((mts & mask) != val) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
            if (guard > 100) begin
                chk("idle_timeout", 32'(mts), 32'(val));
                return;
            end
        end
    endtask

    task automatic pulse();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; det = 1'b0; clear = 1'b0; evt_ready = 1'b0;

        // 1: reset with det high
        do_reset();
        chk("rst_valid", 32'(b_valid), 32'd0);
        chk("rst_count", 32'(b_count), 32'd0);
        chk("rst_det_count", 32'(b_det_count), 32'd0);
        chk("rst_ovf", 32'(b_ovf), 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // 2: single pulse at ts=5, then pop
        idle_to(5, 16'hFFFF);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_valid", 32'(b_valid), 32'd1);
        chk("t2_ts", 32'(b_ts), 32'd5);
        chk("t2_count", 32'(b_count), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("t2_pop_valid", 32'(b_valid), 32'd0);
        chk("t2_pop_count", 32'(b_count), 32'd0);

        // 3: five pulses into a 4-deep FIFO
        step(1'b0, 1'b1, 1'b0);
        idle_to(10, 16'hFFFF);
        repeat (5) pulse();
        chk("t3_count", 32'(b_count), 32'd4);
        chk("t3_ovf", 32'(b_ovf), 32'd1);
        chk("t3_det_count", 32'(b_det_count), 32'd5);
        for (int k = 0; k < 4; k++) begin
            chk("t3_drain_ts", 32'(b_ts), 32'(10 + 2 * k));
            step(1'b0, 1'b0, 1'b1);
        end
        chk("t3_empty", 32'(b_valid), 32'd0);

        // 4: push+pop while full
        step(1'b0, 1'b1, 1'b0);
        idle_to(40, 16'hFFFF);
        repeat (4) pulse();
        step(1'b1, 1'b0, 1'b1);
        chk("t4_count", 32'(b_count), 32'd4);
        chk("t4_ovf", 32'(b_ovf), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_ts", 32'(b_ts), 32'(42 + 2 * k));
            step(1'b0, 1'b0, 1'b1);
        end

        // 5: det held high three cycles
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
`ifdef DETLOG_RISE_EN
        chk("t5_count", 32'(b_count), 32'd1);
        chk("t5_det_count", 32'(b_det_count), 32'd1);
`else
        chk("t5_count", 32'(b_count), 32'd3);
        chk("t5_det_count", 32'(b_det_count), 32'd3);
`endif

        // 6: narrow instance timestamp wrap and count saturation
        step(1'b0, 1'b1, 1'b0);
        idle_to(15, 4'hF);
`ifdef DETLOG_RISE_EN
        pulse();
        chk("t6_wrap_hi", 32'(s_ts), 32'hF);
`else
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_wrap_hi", 32'(s_ts), 32'hF);
        step(1'b0, 1'b0, 1'b1);
        chk("t6_wrap_lo", 32'(s_ts), 32'h0);
`endif
        step(1'b0, 1'b1, 1'b0);
        repeat (5) pulse();
        chk("t6_sat", 32'(s_det_count), 32'd3);
        chk("t6_big_cnt", 32'(b_det_count), 32'd5);
        step(1'b0, 1'b1, 1'b0);
        chk("t6_clr_cnt", 32'(s_det_count), 32'd0);
        chk("t6_clr_fifo", 32'(s_count), 32'd0);
        chk("t6_clr_valid", 32'(s_valid), 32'd0);

        // reset mid-stream discards buffered entries
        pulse();
        pulse();
        do_reset();
        chk("mid_rst_count", 32'(b_count), 32'd0);
        chk("mid_rst_ts", 32'(b_ts), 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
